// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sequencer that time-shares one external WIDTH-bit
// ripple adder among NREQ requesters. The winner's operands are registered onto
// the adder and held for SETTLE cycles. The sum is then captured and returned to
// the winner through a one-hot valid/ready response handshake.
module adder_share_arb #(
    parameter int NREQ   = 3,
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH-1:0]        add_s,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    busy
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [LW:0]     NREQ_W    = (LW+1)'(NREQ);
    localparam logic [CW-1:0]   CNT_INIT  = CW'(SETTLE - 1);
    localparam logic [LW-1:0]   LAST_INIT = LW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    state_t            state_reg;
    logic [LW-1:0]     last_reg;
    logic [CW-1:0]     cnt_reg;
    logic [WIDTH-1:0]  add_a_reg;
    logic [WIDTH-1:0]  add_b_reg;
    logic [WIDTH-1:0]  rsp_sum_reg;
    logic [NREQ-1:0]   rsp_valid_reg;

    // Candidate gi is the requester gi+1 places after the last winner, so
    // candidate 0 always holds the highest round-robin priority.
    logic [LW-1:0]     cand_idx [NREQ];
    logic [NREQ-1:0]   cand_hit;
    logic [LW-1:0]     grant_idx;
    logic              grant_any;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [LW:0] cand_sum;
            // Rotate the index past the last winner, wrapping modulo NREQ.
            assign cand_sum      = {1'b0, last_reg} + (LW+1)'(gi + 1);
            assign cand_idx[gi]  = (cand_sum >= NREQ_W) ? LW'(cand_sum - NREQ_W) : LW'(cand_sum);
            assign cand_hit[gi]  = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Pick the first valid candidate in rotated priority order.
    always_comb begin
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_idx = cand_idx[k];
            end
        end
    end

    assign grant_any = |cand_hit;

    // Accept strobe: only in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset_n && (state_reg == ST_IDLE) && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Sequencer: accept, hold operands for the carry ripple, then respond.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            last_reg      <= LAST_INIT;
            cnt_reg       <= '0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            rsp_sum_reg   <= '0;
            rsp_valid_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        add_a_reg <= req_a[grant_idx*WIDTH +: WIDTH];
                        add_b_reg <= req_b[grant_idx*WIDTH +: WIDTH];
                        last_reg  <= grant_idx;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == '0) begin
                        rsp_sum_reg   <= add_s;
                        rsp_valid_reg <= ONE_HOT0 << last_reg;
                        state_reg     <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    // Only the owner's ready bit completes the handshake.
                    if (rsp_ready[last_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_valid = rsp_valid_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: a transaction-level model (owner, age since accept,
// round-robin pointer) predicts every output each cycle, and directed literal
// checks pin the model to hand-computed values.
module tb_adder_share_arb;

    localparam int NREQ   = 3;
    localparam int WIDTH  = 32;
    localparam int SETTLE = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_s;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  busy;

    adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    // The shared adder itself: carry-out dropped.
    assign add_s = add_a + add_b;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: owner of the adder (-1 = free), cycles since accept.
    int              m_owner;
    int              m_age;
    int              m_last;
    logic [WIDTH-1:0] m_a, m_b, m_sum, m_rsp;

    int acc_idx[$];
    int acc_cyc[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = NREQ - 1;
        m_a     = '0;
        m_b     = '0;
        m_sum   = '0;
        m_rsp   = '0;
    endtask

    task automatic model_step();
        int g;
        if (!reset_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            g = rr_pick(req_valid, m_last);
            if (g >= 0) begin
                m_owner = g;
                m_last  = g;
                m_age   = 1;
                m_a     = req_a[g*WIDTH +: WIDTH];
                m_b     = req_b[g*WIDTH +: WIDTH];
                m_sum   = m_a + m_b;
            end
        end else if (m_age >= SETTLE + 1) begin
            if (rsp_ready[m_owner]) m_owner = -1;
        end else begin
            m_age++;
            if (m_age == SETTLE + 1) m_rsp = m_sum;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        logic [NREQ-1:0] er, ev;
        int g;
        @(negedge clk);
        er = '0;
        ev = '0;
        if (reset_n && m_owner < 0) begin
            g = rr_pick(req_valid, m_last);
            if (g >= 0) er[g] = 1'b1;
        end
        if (reset_n && m_owner >= 0 && m_age >= SETTLE + 1) ev[m_owner] = 1'b1;
        check("req_ready", WIDTH'(req_ready), WIDTH'(er));
        check("rsp_valid", WIDTH'(rsp_valid), WIDTH'(ev));
        check("busy", WIDTH'(busy), WIDTH'(m_owner >= 0));
        check("add_a", add_a, m_a);
        check("add_b", add_b, m_b);
        check("rsp_sum", rsp_sum, m_rsp);
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                acc_idx.push_back(i);
                acc_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    // Single-requester transaction with literal expectations on latency and sum.
    task automatic do_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_sum);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid = NREQ'(1) << i;
        #1;
        check("op_ready_c0", WIDTH'(req_ready), WIDTH'(NREQ'(1) << i));
        tick();
        req_valid = '0;
        for (int k = 0; k < SETTLE; k++) begin
            #1;
            check("op_no_rsp_early", WIDTH'(rsp_valid), '0);
            tick();
        end
        #1;
        check("op_rsp_valid", WIDTH'(rsp_valid), WIDTH'(NREQ'(1) << i));
        check("op_rsp_sum", rsp_sum, exp_sum);
        rsp_ready = NREQ'(1) << i;
        tick();
        rsp_ready = '0;
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // T1 / T2: basic sum and wrap-around
        do_op(0, 32'd5, 32'd7, 32'd12);
        do_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        do_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);

        // T3: all requesters valid, responses taken immediately
        req_a = {32'd300, 32'd200, 32'd100};
        req_b = {32'd3, 32'd2, 32'd1};
        req_valid = '1;
        rsp_ready = '1;
        acc_idx.delete();
        acc_cyc.delete();
        for (int k = 0; k < 24; k++) tick();
        req_valid = '0;
        tick();
        tick();
        checks++;
        if (acc_idx.size() != 6) begin
            errors++;
            $display("FAIL t3_accept_count: got %0d expected 6", acc_idx.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                check("t3_grant_order", WIDTH'(acc_idx[k]), WIDTH'(k % 3));
                if (k > 0) check("t3_spacing", WIDTH'(acc_cyc[k] - acc_cyc[k-1]), WIDTH'(SETTLE + 2));
            end
        end

        // T4: owner 0 stalls the response while others keep requesting
        req_valid = '1;
        rsp_ready = '0;
        tick();
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_rsp_valid", WIDTH'(rsp_valid), 32'd1);
            check("t4_rsp_sum", rsp_sum, 32'd101);
            check("t4_req_ready", WIDTH'(req_ready), '0);
            tick();
        end

        // T6: ready on non-owners is ignored
        rsp_ready = 3'b110;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t6_busy", WIDTH'(busy), 32'd1);
            check("t6_rsp_valid", WIDTH'(rsp_valid), 32'd1);
            tick();
        end
        rsp_ready = 3'b001;
        tick();
        #1;
        check("t4_next_grant", WIDTH'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 5; k++) tick();

        // T5: reset pulse during SETTLE aborts the transaction
        rsp_ready = '0;
        req_valid = 3'b110;
        #1;
        check("t5_grant", WIDTH'(req_ready), 32'd4);
        tick();
        tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t5_add_a", add_a, '0);
        check("t5_add_b", add_b, '0);
        check("t5_rsp_sum", rsp_sum, '0);
        check("t5_rsp_valid", WIDTH'(rsp_valid), '0);
        check("t5_req_ready", WIDTH'(req_ready), '0);
        check("t5_busy", WIDTH'(busy), '0);
        tick();
        reset_n = 1'b1;
        #1;
        check("t5_lowest_after_reset", WIDTH'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < 6; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
